// File: rtl/trace_pkg.sv
// Shared trace types, default widths and channel-id sizing helper.
// Imported by the collector and by anything consuming its output.
package trace_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int TS_W_DEF   = 32;
    localparam int NUM_CH_DEF = 4;

    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_ID_W_DEF = ch_id_w(NUM_CH_DEF);

    typedef struct packed {
        logic [TS_W_DEF-1:0]    ts;
        logic [CH_ID_W_DEF-1:0] ch;
        logic [ADDR_W_DEF-1:0]  addr;
        logic [DATA_W_DEF-1:0]  data;
    } trace_output_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with async reset and occupancy level.
// Head reads as zero whenever the FIFO is empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Stale storage is never visible after reset or once drained.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + (PW + 1)'(1);
                2'b01:   level <= level - (PW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/trace_collector.sv
// Round-robin trace collector: timestamps records from NUM_CH trackers
// and serialises them through a FIFO onto one valid/ready output.
module trace_collector
    import trace_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CH       = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int TS_WIDTH     = 32,
    parameter int DROP_ON_FULL = 0,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trace_en,
    input  logic [NUM_CH-1:0]            ch_valid,
    output logic [NUM_CH-1:0]            ch_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [TS_WIDTH-1:0]          trace_ts,
    output logic [ch_id_w(NUM_CH)-1:0]   trace_ch,
    output logic [ADDR_WIDTH-1:0]        trace_addr,
    output logic [DATA_WIDTH-1:0]        trace_data,
    output logic [DROP_CNT_W-1:0]        drop_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int CH_W  = ch_id_w(NUM_CH);
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((DROP_CNT_W > CNT_W) ? DROP_CNT_W : CNT_W) + 1;
    localparam int REC_W = TS_WIDTH + CH_W + ADDR_WIDTH + DATA_WIDTH;
    localparam bit DROP  = (DROP_ON_FULL != 0);

    logic [TS_WIDTH-1:0]   ts;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       offset;
    logic [CH_W-1:0]       gnt;
    logic [CH_W:0]         gnt_sum;
    logic [CH_W:0]         nxt_sum;
    logic [NUM_CH-1:0]     rot;
    logic                  gnt_vld;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  space;
    logic                  push;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [CNT_W-1:0]      n_valid;
    logic [CNT_W-1:0]      n_drop;
    logic [SUM_W-1:0]      drop_sum;
    logic [REC_W-1:0]      rec_in;
    logic [REC_W-1:0]      rec_out;

    // Rotate so the pointer's channel lands at bit 0; lowest set bit wins.
    assign rot = NUM_CH'({ch_valid, ch_valid} >> rr_ptr);

    always_comb begin
        offset  = '0;
        gnt_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset  = CH_W'(k);
                gnt_vld = 1'b1;
            end
        end
    end

    assign gnt_sum = {1'b0, rr_ptr} + {1'b0, offset};
    assign gnt     = (gnt_sum >= (CH_W + 1)'(NUM_CH))
                   ? CH_W'(gnt_sum - (CH_W + 1)'(NUM_CH))
                   : gnt_sum[CH_W-1:0];
    assign nxt_sum = {1'b0, gnt} + (CH_W + 1)'(1);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        n_valid  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt == CH_W'(k)) begin
                sel_addr = ch_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            n_valid = n_valid + CNT_W'(ch_valid[k]);
        end
    end

    // A full FIFO still admits a push when the sink drains the head.
    assign pop   = trace_ready && !empty;
    assign space = !full || pop;
    assign push  = trace_en && gnt_vld && space;

    always_comb begin
        ch_ready = '0;
        if (DROP)           ch_ready = '1;
        else if (rst)       ch_ready = '0;
        else if (!trace_en) ch_ready = '1;
        else if (push)      ch_ready[gnt] = 1'b1;
    end

    assign n_drop   = n_valid - CNT_W'(push);
    assign drop_sum = SUM_W'(drop_count) + SUM_W'(n_drop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts     <= '0;
            rr_ptr <= '0;
        end else begin
            if (trace_en) ts <= ts + TS_WIDTH'(1);
            if (trace_en && gnt_vld && (DROP || space)) begin
                rr_ptr <= (nxt_sum >= (CH_W + 1)'(NUM_CH))
                        ? '0 : nxt_sum[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (DROP && trace_en) begin
            if (drop_sum > SUM_W'({DROP_CNT_W{1'b1}})) drop_count <= '1;
            else drop_count <= drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign rec_in = {ts, gnt, sel_addr, sel_data};

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign trace_valid = !empty;
    assign {trace_ts, trace_ch, trace_addr, trace_data} = rec_out;

endmodule

// File: tb/tb_trace_collector.sv
// Bench for trace_collector: back-pressure instance against a scoreboard
// model, plus drop-mode and narrow-timestamp instances checked by hand.
module tb_trace_collector;

    typedef struct {
        logic [31:0] ts;
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        logic [3:0] valid;
        logic       ready;
        logic [3:0] exp_rdy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         trace_en = 1'b0;
    logic         trace_ready = 1'b0;
    logic [3:0]   ch_valid = '0;
    logic [31:0]  a [4];
    logic [31:0]  d [4];
    logic [127:0] ch_addr;
    logic [127:0] ch_data;

    logic [3:0]  rdy, rdy_d, rdy_s;
    logic        vld, vld_d, vld_s;
    logic [31:0] ts, ts_d;
    logic [3:0]  ts_s;
    logic [1:0]  ch, ch_d, ch_s;
    logic [31:0] ad, ad_d, ad_s, dt, dt_d, dt_s;
    logic [15:0] dc, dc_d;
    logic [1:0]  dc_s;
    logic [3:0]  lv, lv_d, lv_s;

    rec_t        sb[$];
    vec_t        tbl[12];
    int          m_rr;
    logic [31:0] m_ts;
    logic [3:0]  obs_rdy;
    int          n_chk = 0;
    int          n_fail = 0;

    assign ch_addr = {a[3], a[2], a[1], a[0]};
    assign ch_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    trace_collector dut (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .ch_valid(ch_valid), .ch_ready(rdy),
        .ch_addr(ch_addr), .ch_data(ch_data),
        .trace_valid(vld), .trace_ready(trace_ready),
        .trace_ts(ts), .trace_ch(ch), .trace_addr(ad), .trace_data(dt),
        .drop_count(dc), .fifo_level(lv)
    );

    trace_collector #(.DROP_ON_FULL(1)) dut_d (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .ch_valid(ch_valid), .ch_ready(rdy_d),
        .ch_addr(ch_addr), .ch_data(ch_data),
        .trace_valid(vld_d), .trace_ready(trace_ready),
        .trace_ts(ts_d), .trace_ch(ch_d), .trace_addr(ad_d), .trace_data(dt_d),
        .drop_count(dc_d), .fifo_level(lv_d)
    );

    trace_collector #(.DROP_ON_FULL(1), .DROP_CNT_W(2), .TS_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .ch_valid(ch_valid), .ch_ready(rdy_s),
        .ch_addr(ch_addr), .ch_data(ch_data),
        .trace_valid(vld_s), .trace_ready(trace_ready),
        .trace_ts(ts_s), .trace_ch(ch_s), .trace_addr(ad_s), .trace_data(dt_s),
        .drop_count(dc_s), .fifo_level(lv_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of the reference model for the back-pressure instance.
    task automatic step();
        int         g;
        bit         pop;
        bit         push;
        logic [3:0] mr;
        rec_t       r;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && ch_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        pop  = (sb.size() > 0) && trace_ready;
        push = trace_en && (g >= 0) && ((sb.size() < 8) || pop);
        mr   = !trace_en ? 4'hF : (push ? 4'(1 << g) : 4'h0);
        obs_rdy = rdy;
        chk("ch_ready", rdy, mr);
        chk("trace_valid", vld, sb.size() > 0);
        chk("fifo_level", lv, sb.size());
        if (sb.size() > 0) begin
            chk("head_ts", ts, sb[0].ts);
            chk("head_ch", ch, sb[0].ch);
            chk("head_addr", ad, sb[0].addr);
            chk("head_data", dt, sb[0].data);
        end
        if (push) begin
            r.ts   = m_ts;
            r.ch   = 2'(g);
            r.addr = a[g];
            r.data = d[g];
        end
        @(posedge clk);
        if (pop) void'(sb.pop_front());
        if (push) begin
            sb.push_back(r);
            m_rr = (g + 1) % 4;
        end
        if (trace_en) m_ts = m_ts + 32'd1;
        #1;
        if (push) begin
            a[g] = a[g] + 32'h10;
            d[g] = $urandom;
        end
    endtask

    task automatic do_reset();
        trace_en    = 1'b0;
        trace_ready = 1'b0;
        ch_valid    = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_valid", vld, 0);
        chk("rst_level", lv, 0);
        chk("rst_ts", ts, 0);
        chk("rst_addr", ad, 0);
        chk("rst_ready", rdy, 4'h0);
        chk("rst_ready_drop", rdy_d, 4'hF);
        chk("rst_drop_cnt", dc_d, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_rr = 0;
        m_ts = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h1000 * (i + 1);
            d[i] = i;
        end
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[5]  = '{4'b1001, 1'b1, 4'b1000};
        tbl[6]  = '{4'b0110, 1'b1, 4'b0010};
        tbl[7]  = '{4'b0010, 1'b1, 4'b0010};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0101, 1'b1, 4'b0100};
        tbl[10] = '{4'b0001, 1'b1, 4'b0001};
        tbl[11] = '{4'b1111, 1'b0, 4'b0010};

        // Single record after five idle cycles.
        do_reset();
        trace_en = 1'b1;
        repeat (5) step();
        a[0] = 32'h100;
        d[0] = 32'hAA;
        ch_valid = 4'b0001;
        step();
        ch_valid = '0;
        chk("t1_valid", vld, 1);
        chk("t1_ts", ts, 5);
        chk("t1_ch", ch, 0);
        chk("t1_level", lv, 1);
        chk("t1_addr", ad, 32'h100);
        chk("t1_data", dt, 32'hAA);
        trace_ready = 1'b1;
        step();
        chk("t1_pop_level", lv, 0);

        // Round-robin table.
        do_reset();
        trace_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ch_valid    = tbl[i].valid;
            trace_ready = tbl[i].ready;
            step();
            chk("tbl_ready", obs_rdy, tbl[i].exp_rdy);
        end
        ch_valid    = '0;
        trace_ready = 1'b1;
        repeat (3) step();

        // Back-pressure fill, then push+pop while full.
        do_reset();
        trace_en = 1'b1;
        ch_valid = 4'b0010;
        repeat (10) step();
        chk("t3_level_full", lv, 8);
        chk("t3_ready_held", rdy[1], 0);
        trace_ready = 1'b1;
        step();
        chk("t3_level_pushpop", lv, 8);
        ch_valid = '0;
        repeat (9) step();
        chk("t3_drained", lv, 0);

        // Drop-on-full counting and saturation.
        do_reset();
        trace_en = 1'b1;
        ch_valid = 4'b0001;
        repeat (8) step();
        chk("t4_level", lv_d, 8);
        chk("t4_no_drop", dc_d, 0);
        ch_valid = 4'b0111;
        repeat (2) step();
        chk("t4_drop6", dc_d, 6);
        chk("t4_sat", dc_s, 3);
        chk("t4_ready_all", rdy_d, 4'hF);
        trace_ready = 1'b1;
        step();
        chk("t4_drop8", dc_d, 8);
        chk("t4_sat_hold", dc_s, 3);

        // Narrow timestamp wrap and trace_en freeze.
        do_reset();
        trace_en = 1'b1;
        repeat (16) step();
        ch_valid = 4'b0001;
        step();
        chk("t5_valid", vld_s, 1);
        chk("t5_ts_wrap", ts_s, 0);
        chk("t5_ch", ch_s, 0);
        trace_en = 1'b0;
        ch_valid = 4'b0110;
        repeat (3) step();
        chk("t5_frozen_level", lv_s, 1);
        chk("t5_no_drop", dc_s, 0);
        trace_en    = 1'b1;
        ch_valid    = 4'b0001;
        trace_ready = 1'b1;
        step();
        ch_valid    = '0;
        trace_ready = 1'b0;
        chk("t5_ts_frozen", ts_s, 1);
        chk("t5_level", lv_s, 1);
        step();

        // Asynchronous reset mid-stream.
        do_reset();
        trace_en = 1'b1;
        ch_valid = 4'b0011;
        repeat (5) step();
        chk("t6_level", lv, 5);
        chk("t6_level_drop", lv_d, 5);
        chk("t6_drops", dc_d, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", vld, 0);
        chk("t6_level0", lv, 0);
        chk("t6_level0_drop", lv_d, 0);
        chk("t6_drop0", dc_d, 0);
        do_reset();
        trace_en = 1'b1;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
